// File: rtl/grid_cursor_ctrl.sv
// Grid cursor: debounced-by-frame button stepping, pixel-to-tile map (1 clk), and one-shot selection handshake.
// sel_req holds with a stable sel_id until sel_ack; clear_sel or reset drops it the next cycle.
module grid_cursor_ctrl #(
  parameter int COLS          = 5,
  parameter int ROWS          = 5,
  parameter int TILE_SHIFT    = 6,
  parameter int ORG_X         = 1,
  parameter int ORG_Y         = 1,
  parameter int WRAP          = 0,
  parameter int REPEAT_FRAMES = 15,
  parameter int ID_W          = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            screen_end,
  input  logic [9:0]      x,
  input  logic [8:0]      y,
  input  logic            up,
  input  logic            down,
  input  logic            left,
  input  logic            right,
  input  logic            middle,
  input  logic            clear_sel,
  output logic [4:0]      cursor_col,
  output logic [4:0]      cursor_row,
  output logic [ID_W-1:0] cursor_id,
  output logic [ID_W-1:0] tile_id,
  output logic            tile_valid,
  output logic            on_cursor,
  output logic            sel_req,
  output logic [ID_W-1:0] sel_id,
  input  logic            sel_ack
);

  localparam int CW = (REPEAT_FRAMES > 2) ? $clog2(REPEAT_FRAMES) : 1;
  localparam logic [CW-1:0]   RPT_LAST = CW'(REPEAT_FRAMES - 1);
  localparam logic [4:0]      COL_MAX  = 5'(COLS - 1);
  localparam logic [4:0]      ROW_MAX  = 5'(ROWS - 1);
  localparam logic [ID_W-1:0] COLS_ID  = ID_W'(COLS);
  localparam logic [9:0]      X_LO     = 10'(ORG_X);
  localparam logic [9:0]      X_HI     = 10'(ORG_X + COLS);
  localparam logic [8:0]      Y_LO     = 9'(ORG_Y);
  localparam logic [8:0]      Y_HI     = 9'(ORG_Y + ROWS);
  localparam bit              DO_WRAP  = (WRAP != 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} sel_state_t;

  // {middle, right, left, down, up}
  logic [4:0] btn_meta, btn_sync;
  logic       up_s, down_s, left_s, right_s, mid_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= {middle, right, left, down, up};
      btn_sync <= btn_meta;
    end
  end

  assign up_s    = btn_sync[0];
  assign down_s  = btn_sync[1];
  assign left_s  = btn_sync[2];
  assign right_s = btn_sync[3];
  assign mid_s   = btn_sync[4];

  logic          any_dir, held_q;
  logic [CW-1:0] rpt_cnt, cnt_inc;
  logic [4:0]    col_n, row_n;

  assign any_dir = up_s | down_s | left_s | right_s;
  assign cnt_inc = rpt_cnt + 1'b1;

  // Opposing buttons cancel per axis; edges clamp or wrap.
  always_comb begin
    col_n = cursor_col;
    row_n = cursor_row;
    if (right_s && !left_s)
      col_n = (cursor_col == COL_MAX) ? (DO_WRAP ? 5'd0 : cursor_col) : cursor_col + 5'd1;
    else if (left_s && !right_s)
      col_n = (cursor_col == 5'd0) ? (DO_WRAP ? COL_MAX : cursor_col) : cursor_col - 5'd1;
    if (down_s && !up_s)
      row_n = (cursor_row == ROW_MAX) ? (DO_WRAP ? 5'd0 : cursor_row) : cursor_row + 5'd1;
    else if (up_s && !down_s)
      row_n = (cursor_row == 5'd0) ? (DO_WRAP ? ROW_MAX : cursor_row) : cursor_row - 5'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cursor_col <= '0;
      cursor_row <= '0;
      held_q     <= 1'b0;
      rpt_cnt    <= '0;
    end else if (screen_end) begin
      if (!any_dir) begin
        held_q  <= 1'b0;
        rpt_cnt <= '0;
      end else if (!held_q) begin
        held_q     <= 1'b1;
        rpt_cnt    <= '0;
        cursor_col <= col_n;
        cursor_row <= row_n;
      end else if (cnt_inc == RPT_LAST) begin
        rpt_cnt    <= '0;
        cursor_col <= col_n;
        cursor_row <= row_n;
      end else begin
        rpt_cnt <= cnt_inc;
      end
    end
  end

  assign cursor_id = ID_W'(cursor_row) * COLS_ID + ID_W'(cursor_col);

  logic [9:0] tx, rel_x;
  logic [8:0] ty, rel_y;
  logic       map_vld;

  assign tx      = x >> TILE_SHIFT;
  assign ty      = y >> TILE_SHIFT;
  assign rel_x   = tx - X_LO;
  assign rel_y   = ty - Y_LO;
  assign map_vld = (tx >= X_LO) && (tx < X_HI) && (ty >= Y_LO) && (ty < Y_HI);

  always_ff @(posedge clk) begin
    if (!reset) begin
      tile_id    <= '0;
      tile_valid <= 1'b0;
      on_cursor  <= 1'b0;
    end else begin
      tile_valid <= map_vld;
      tile_id    <= map_vld ? ID_W'(rel_y) * COLS_ID + ID_W'(rel_x) : '0;
      on_cursor  <= map_vld && (rel_x == 10'(cursor_col)) && (rel_y == 9'(cursor_row));
    end
  end

  sel_state_t sel_state;
  logic       mid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_state <= S_IDLE;
      sel_req   <= 1'b0;
      sel_id    <= '0;
      mid_q     <= 1'b0;
    end else begin
      mid_q <= mid_s;
      if (clear_sel) begin
        sel_state <= S_IDLE;
        sel_req   <= 1'b0;
      end else begin
        case (sel_state)
          S_IDLE: if (mid_s && !mid_q) begin
            sel_state <= S_REQ;
            sel_req   <= 1'b1;
            sel_id    <= cursor_id;
          end
          S_REQ: if (sel_ack) begin
            sel_state <= S_HOLD;
            sel_req   <= 1'b0;
          end
          S_HOLD: if (!mid_s) sel_state <= S_IDLE;
          default: begin
            sel_state <= S_IDLE;
            sel_req   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Directed bench for grid_cursor_ctrl: clamp instance (dut) and wrap instance (dutw) share stimulus.
module tb_grid_cursor_ctrl;

  logic       clk = 1'b0;
  logic       reset, screen_end;
  logic [9:0] x;
  logic [8:0] y;
  logic       up, down, left, right, middle, clear_sel, sel_ack;

  logic [4:0] c_col, c_row, w_col, w_row;
  logic [9:0] c_cid, c_tid, c_sid, w_cid, w_tid, w_sid;
  logic       c_tv, c_oc, c_req, w_tv, w_oc, w_req;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  grid_cursor_ctrl dut (
    .clk(clk), .reset(reset), .screen_end(screen_end), .x(x), .y(y),
    .up(up), .down(down), .left(left), .right(right), .middle(middle),
    .clear_sel(clear_sel), .cursor_col(c_col), .cursor_row(c_row),
    .cursor_id(c_cid), .tile_id(c_tid), .tile_valid(c_tv), .on_cursor(c_oc),
    .sel_req(c_req), .sel_id(c_sid), .sel_ack(sel_ack)
  );

  grid_cursor_ctrl #(.WRAP(1)) dutw (
    .clk(clk), .reset(reset), .screen_end(screen_end), .x(x), .y(y),
    .up(up), .down(down), .left(left), .right(right), .middle(middle),
    .clear_sel(clear_sel), .cursor_col(w_col), .cursor_row(w_row),
    .cursor_id(w_cid), .tile_id(w_tid), .tile_valid(w_tv), .on_cursor(w_oc),
    .sel_req(w_req), .sel_id(w_sid), .sel_ack(sel_ack)
  );

  typedef struct {
    int x;
    int y;
    int vld;
    int id;
    int oc;
  } map_vec_t;

  map_vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    tick();
  endtask

  task automatic set_dir(input logic u, input logic d, input logic l, input logic r);
    up = u; down = d; left = l; right = r;
    tick(3);
  endtask

  // One-step move: press, one frame, release, one frame to clear the held flag.
  task automatic move(input logic u, input logic d, input logic l, input logic r);
    set_dir(u, d, l, r);
    frame();
    set_dir(0, 0, 0, 0);
    frame();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (c_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int cnt, exp_col;

    vecs[0] = '{130, 200, 1, 11, 0};
    vecs[1] = '{10,  200, 0, 0,  0};
    vecs[2] = '{384, 200, 0, 0,  0};
    vecs[3] = '{64,  64,  1, 0,  1};
    vecs[4] = '{319, 319, 1, 18, 0};
    vecs[5] = '{383, 383, 1, 24, 0};
    vecs[6] = '{384, 100, 0, 0,  0};
    vecs[7] = '{100, 63,  0, 0,  0};
    vecs[8] = '{100, 384, 0, 0,  0};

    reset = 1'b0; screen_end = 1'b0; x = '0; y = '0;
    up = 0; down = 0; left = 0; right = 0; middle = 0; clear_sel = 0; sel_ack = 0;
    tick(3);
    chk("rst_col", c_col, 0);
    chk("rst_row", c_row, 0);
    chk("rst_req", c_req, 0);
    chk("rst_sid", c_sid, 0);
    chk("rst_tv", c_tv, 0);
    chk("rst_tid", c_tid, 0);
    chk("rst_oc", c_oc, 0);
    reset = 1'b1;
    tick(2);

    // Pixel map, cursor at (0,0)
    foreach (vecs[i]) begin
      x = 10'(vecs[i].x);
      y = 9'(vecs[i].y);
      tick();
      chk($sformatf("map%0d_vld", i), c_tv, vecs[i].vld);
      chk($sformatf("map%0d_id", i), c_tid, vecs[i].id);
      chk($sformatf("map%0d_oc", i), c_oc, vecs[i].oc);
    end

    // Auto-repeat: steps at frames 1, 15, 29
    set_dir(0, 0, 0, 1);
    for (int f = 1; f <= 40; f++) begin
      frame();
      exp_col = (f >= 29) ? 3 : (f >= 15) ? 2 : 1;
      chk($sformatf("rpt_f%0d", f), c_col, exp_col);
    end
    chk("rpt_wcol", w_col, 3);
    set_dir(0, 0, 0, 0);
    frame();

    move(0, 0, 0, 1);
    chk("to4_col", c_col, 4);
    move(0, 0, 0, 1);
    chk("clamp_col", c_col, 4);
    chk("wrap_col", w_col, 0);
    chk("clamp_row", c_row, 0);
    move(1, 0, 0, 0);
    chk("clamp_up", c_row, 0);
    chk("wrap_up", w_row, 4);

    move(0, 1, 1, 1);
    chk("lr_cancel_col", c_col, 4);
    chk("lr_cancel_row", c_row, 1);
    chk("lr_wrap_row", w_row, 0);

    move(0, 1, 1, 0);
    chk("diag_col", c_col, 3);
    chk("diag_row", c_row, 2);
    chk("diag_wcol", w_col, 4);
    chk("diag_wrow", w_row, 1);
    move(0, 1, 1, 0);
    chk("at23_col", c_col, 2);
    chk("at23_row", c_row, 3);
    chk("at23_id", c_cid, 17);

    // Pulsed middle at (2,3)
    middle = 1'b1;
    wait_req(ok);
    chk("req_seen", ok, 1);
    chk("req_sid", c_sid, 17);
    chk("req_wsid", w_sid, 13);
    middle = 1'b0;
    tick(5);
    chk("req_hold", c_req, 1);
    move(0, 0, 0, 1);
    chk("move_in_req", c_col, 3);
    chk("sid_stable", c_sid, 17);
    chk("req_still", c_req, 1);
    sel_ack = 1'b1;
    tick();
    sel_ack = 1'b0;
    chk("ack_drop", c_req, 0);
    tick(4);

    // Held middle across ack: one request only
    middle = 1'b1;
    wait_req(ok);
    chk("req2_seen", ok, 1);
    chk("req2_sid", c_sid, 18);
    sel_ack = 1'b1;
    tick();
    sel_ack = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (c_req) cnt++;
    end
    chk("held_no_rereq", cnt, 0);
    middle = 1'b0;
    tick(4);

    // clear_sel and sel_ack together while requesting
    middle = 1'b1;
    wait_req(ok);
    chk("req3_seen", ok, 1);
    clear_sel = 1'b1;
    sel_ack = 1'b1;
    tick();
    clear_sel = 1'b0;
    sel_ack = 1'b0;
    chk("clear_drop", c_req, 0);
    middle = 1'b0;
    tick(4);

    // clear_sel beats a middle press
    clear_sel = 1'b1;
    middle = 1'b1;
    tick(6);
    chk("clear_blocks", c_req, 0);
    clear_sel = 1'b0;
    tick(4);
    chk("clear_no_late", c_req, 0);
    middle = 1'b0;
    tick(4);

    // Reset mid-request
    x = 10'd130;
    y = 9'd200;
    middle = 1'b1;
    wait_req(ok);
    chk("req4_seen", ok, 1);
    chk("tv_before_rst", c_tv, 1);
    middle = 1'b0;
    reset = 1'b0;
    tick();
    chk("rst_mid_req", c_req, 0);
    chk("rst_mid_col", c_col, 0);
    chk("rst_mid_sid", c_sid, 0);
    chk("rst_mid_tv", c_tv, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_tid", c_tid, 11);
    chk("post_rst_req", c_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
